// File: rtl/uart_tx_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_pkt_arbiter                                       |
// | Function : Round-robin packetiser sharing one UART byte transmitter  |
// |            between two byte-stream sources. Each packet is sent as   |
// |            SYNC, channel ID, payload bytes, XOR checksum.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_tx_pkt_arbiter #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [7:0] GAP_CYCLES = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       grant,
  output logic       pkt_done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_ID      = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       grant_q, grant_d;
  logic [7:0] csum_q, csum_d;
  logic       csum_ld_q, csum_ld_d;   // checksum byte already in the output register
  logic [7:0] gap_q, gap_d;

  logic       xfer;
  logic       pay_ready;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;

  // Next-state, output-register and handshake logic for the packet FSM
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    grant_d    = grant_q;
    csum_d     = csum_q;
    csum_ld_d  = csum_ld_q;
    gap_d      = gap_q;
    pkt_done   = 1'b0;

    xfer      = tx_valid_q & tx_ready;
    sel_valid = grant_q ? s1_valid : s0_valid;
    sel_last  = grant_q ? s1_last  : s0_last;
    sel_data  = grant_q ? s1_data  : s0_data;
    // A payload byte can be taken when the output register is empty or draining
    pay_ready = (state_q == ST_PAYLOAD) & (~tx_valid_q | tx_ready);
    s0_ready  = pay_ready & ~grant_q;
    s1_ready  = pay_ready &  grant_q;

    // A transferred byte leaves the register empty unless reloaded below
    if (xfer) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s0_valid | s1_valid) begin
          // On a tie the channel that did not own the last packet wins
          grant_d    = (s0_valid & s1_valid) ? ~grant_q : s1_valid;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          csum_d     = 8'h00;
          csum_ld_d  = 1'b0;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          tx_data_d  = {7'b0, grant_q};
          tx_valid_d = 1'b1;
          state_d    = ST_ID;
        end
      end
      ST_ID: begin
        if (xfer) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (sel_valid & pay_ready) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          csum_d     = csum_q ^ sel_data;
          if (sel_last) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        // First transfer here drains the last payload byte, second the checksum
        if (xfer) begin
          if (!csum_ld_q) begin
            tx_data_d  = csum_q;
            tx_valid_d = 1'b1;
            csum_ld_d  = 1'b1;
          end else begin
            pkt_done = 1'b1;
            gap_d    = 8'd0;
            state_d  = (GAP_CYCLES == 8'd0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_CYCLES - 8'd1) begin
          gap_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      grant_q    <= 1'b1;
      csum_q     <= 8'h00;
      csum_ld_q  <= 1'b0;
      gap_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      csum_q     <= csum_d;
      csum_ld_q  <= csum_ld_d;
      gap_q      <= gap_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx_pkt_arbiter                                    |
// | Function : Directed self-checking bench for uart_tx_pkt_arbiter,     |
// |            default instance plus a zero-gap instance.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_tx_pkt_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic       tx_ready = 1'b1;
  logic       tgl = 1'b0;   // toggle tx_ready every cycle when set
  logic       sel = 1'b0;   // 0: default instance observed, 1: zero-gap instance

  logic [7:0] a_tx_data, b_tx_data;
  logic       a_s0_ready, a_s1_ready, a_tx_valid, a_busy, a_grant, a_pkt_done;
  logic       b_s0_ready, b_s1_ready, b_tx_valid, b_busy, b_grant, b_pkt_done;

  logic [7:0] w_tx_data;
  logic       w_s0_ready, w_s1_ready, w_tx_valid, w_busy, w_grant, w_pkt_done;
  assign w_tx_data  = sel ? b_tx_data  : a_tx_data;
  assign w_tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign w_s0_ready = sel ? b_s0_ready : a_s0_ready;
  assign w_s1_ready = sel ? b_s1_ready : a_s1_ready;
  assign w_busy     = sel ? b_busy     : a_busy;
  assign w_grant    = sel ? b_grant    : a_grant;
  assign w_pkt_done = sel ? b_pkt_done : a_pkt_done;

  uart_tx_pkt_arbiter u_dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(a_s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(a_s1_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .busy(a_busy), .grant(a_grant), .pkt_done(a_pkt_done)
  );

  uart_tx_pkt_arbiter #(.SYNC_BYTE(8'hA5), .GAP_CYCLES(8'd0)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(b_s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(b_s1_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready),
    .busy(b_busy), .grant(b_grant), .pkt_done(b_pkt_done)
  );

  always #5 clk = ~clk;

  logic [8:0] q0[$], q1[$];      // {last, data} pending per source
  logic [7:0] cap[$], ex[$];     // captured and expected tx stream
  int         capc[$];           // cycle index of each captured byte
  int         cyc = 0, ndone = 0, xerr = 0, serr = 0;
  int         ncmp = 0, nerr = 0;
  logic       acc0 = 1'b0, acc1 = 1'b0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  // Sources: retire accepted bytes, present the next one, drive tx_ready
  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    s0_valid = (q0.size() > 0);
    {s0_last, s0_data} = (q0.size() > 0) ? q0[0] : 9'h000;
    s1_valid = (q1.size() > 0);
    {s1_last, s1_data} = (q1.size() > 0) ? q1[0] : 9'h000;
    tx_ready = tgl ? ~tx_ready : 1'b1;
  end

  // Monitor: capture transfers, count pulses, watch handshake rules
  always @(negedge clk) begin
    cyc++;
    if (w_tx_valid === 1'b1 && tx_ready) begin
      cap.push_back(w_tx_data);
      capc.push_back(cyc);
    end
    if (w_pkt_done === 1'b1) ndone++;
    if ((w_s0_ready === 1'b1 && w_grant === 1'b1) || (w_s1_ready === 1'b1 && w_grant === 1'b0)) xerr++;
    if (pv && !pr && (w_tx_valid !== 1'b1 || w_tx_data !== pd)) serr++;
    pv   = (w_tx_valid === 1'b1);
    pr   = tx_ready;
    pd   = w_tx_data;
    acc0 = s0_valid & (w_s0_ready === 1'b1);
    acc1 = s1_valid & (w_s1_ready === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_stream(input string tag);
    int k = 0;
    while (cap.size() < ex.size() && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_len"}, cap.size(), ex.size());
    for (int i = 0; i < ex.size() && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'h0, cap[i]}, {24'h0, ex[i]});
  endtask

  initial begin
    int base;
    int k;
    int g;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", w_tx_valid, 0);
    chk("rst_tx_data",  w_tx_data, 0);
    chk("rst_busy",     w_busy, 0);
    chk("rst_grant",    w_grant, 1);
    chk("rst_s0_ready", w_s0_ready, 0);
    chk("rst_s1_ready", w_s1_ready, 0);
    chk("rst_pkt_done", w_pkt_done, 0);

    // ch0 three-byte packet, checksum 01^02^03 = 00, then a 4-clock gap
    step();
    base = ndone;
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
    ex = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    k = 0;
    do begin @(negedge clk); k++; end while (w_pkt_done !== 1'b1 && k < 200);
    chk("t1_pkt_done_seen", w_pkt_done, 1);
    g = 0;
    @(negedge clk);
    while (w_busy === 1'b1 && g < 50) begin g++; @(negedge clk); end
    chk("t1_gap_busy_clocks", g, 4);
    expect_stream("t1");
    chk("t1_pkt_done_count", ndone - base, 1);

    // simultaneous requests after reset: ch0 first, then ch1
    pulse_rst();
    cap.delete(); capc.delete();
    q0.push_back({1'b1, 8'h10});
    q1.push_back({1'b1, 8'h20});
    ex = '{8'hA5, 8'h00, 8'h10, 8'h10, 8'hA5, 8'h01, 8'h20, 8'h20};
    expect_stream("t2a");

    // ties alternate: ch0, ch1, ch0
    step();
    cap.delete(); capc.delete();
    q0.push_back({1'b1, 8'h30}); q0.push_back({1'b1, 8'h31});
    q1.push_back({1'b1, 8'h40});
    ex = '{8'hA5, 8'h00, 8'h30, 8'h30, 8'hA5, 8'h01, 8'h40, 8'h40,
           8'hA5, 8'h00, 8'h31, 8'h31};
    expect_stream("t2b");

    // ch1 single byte with tx_ready toggling
    step();
    cap.delete(); capc.delete();
    base = serr;
    tgl = 1'b1;
    q1.push_back({1'b1, 8'h5A});
    ex = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
    expect_stream("t3");
    chk("t3_stall_stability", serr - base, 0);
    tgl = 1'b0;

    // ch1 eight-byte burst, ch0 arriving mid-packet must wait
    step(); step();
    cap.delete(); capc.delete();
    base = xerr;
    for (int i = 1; i <= 8; i++) q1.push_back({(i == 8), 8'(i * 17)});
    step(); step(); step();
    q0.push_back({1'b1, 8'h99});
    step(); step();
    @(negedge clk);
    chk("t4_s0_valid_mid", s0_valid, 1);
    chk("t4_s0_ready_mid", w_s0_ready, 0);
    ex = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
           8'h88, 8'hA5, 8'h00, 8'h99, 8'h99};
    expect_stream("t4");
    if (capc.size() > 9) chk("t4_burst_span", capc[9] - capc[2], 7);
    else chk("t4_burst_span_missing", capc.size(), 10);
    chk("t4_cross_ready", xerr - base, 0);

    // reset in the middle of a stalled ch1 packet
    step();
    cap.delete(); capc.delete();
    q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b0, 8'hC2});
    ex = '{8'hA5, 8'h01, 8'hC1, 8'hC2};
    expect_stream("t5_pre");
    chk("t5_busy_stalled", w_busy, 1);
    pulse_rst();
    @(negedge clk);
    chk("t5_tx_valid", w_tx_valid, 0);
    chk("t5_busy", w_busy, 0);
    chk("t5_grant", w_grant, 1);
    repeat (8) @(negedge clk);
    chk("t5_no_csum", cap.size(), 4);
    step();
    cap.delete(); capc.delete();
    q0.push_back({1'b1, 8'h77});
    ex = '{8'hA5, 8'h00, 8'h77, 8'h77};
    expect_stream("t5_post");

    // zero-gap instance: next SYNC one clock after checksum transfer
    sel = 1'b1;
    pulse_rst();
    cap.delete(); capc.delete();
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b1, 8'h02});
    q1.push_back({1'b1, 8'h03});
    ex = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA5, 8'h01, 8'h03, 8'h03};
    expect_stream("t6");
    if (capc.size() > 5) chk("t6_sync_spacing", capc[5] - capc[4], 2);
    else chk("t6_sync_spacing_missing", capc.size(), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_pkt_arbiter.md
Name: uart_tx_pkt_arbiter

Overview:
- Shares the single UART byte transmitter (TXD path) between two byte-stream requesters.
  - Channel 0: status/command responses.
  - Channel 1: scope sample data.
- Frames each request as one packet: SYNC, channel ID, payload bytes, XOR checksum.
- Arbitrates round-robin per packet; a packet is never preempted once started.
- Feeds the UART transmitter over a valid/ready byte handshake.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- GAP_CYCLES, 4, idle clocks after each checksum byte before the next arbitration; 0 is legal. Width 8 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s0_data  in  8  channel 0 payload byte
- s0_valid  in  1  channel 0 byte valid
- s0_last  in  1  channel 0 final payload byte of packet
- s0_ready  out  1  channel 0 byte accepted this cycle when high with s0_valid
- s1_data, s1_valid, s1_last, s1_ready: same as channel 0, for channel 1
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART transmitter accepts byte
- busy  out  1  high in any state other than IDLE
- grant  out  1  channel owning the current or last packet
- pkt_done  out  1  one-cycle pulse when a checksum byte is accepted (tx_valid & tx_ready in CSUM)

Behaviour:
- Synchronous reset, effective regardless of state, mid-packet included. Reset values:
  - state=IDLE; tx_valid=0; tx_data=0; s0_ready=s1_ready=0.
  - busy=0; grant=1, so channel 0 wins the first tie; pkt_done=0; checksum=0; gap counter=0.
  - A partially sent packet is abandoned. No checksum is emitted.
- Output register: tx_data/tx_valid are registered. Once tx_valid=1, tx_data must stay stable until tx_valid & tx_ready.
- Transfer rule: a byte moves when tx_valid & tx_ready.
  - If no new byte is loaded in that cycle, tx_valid drops to 0 next cycle.
- States:
  - IDLE
    - If either s_valid is high, pick a channel and go to HDR.
    - Only one valid: grant that channel.
    - Both valid: grant the channel != previous grant.
    - Load tx_data=SYNC_BYTE, tx_valid=1, checksum=0.
    - Latency: s_valid high at edge t gives tx_valid with SYNC_BYTE at edge t+1.
    - No payload byte is accepted in IDLE.
  - HDR: on transfer, load tx_data={7'b0,grant}; go to ID.
  - ID: on transfer, go to PAYLOAD. tx_valid falls unless a payload byte is loaded in the same cycle.
  - PAYLOAD
    - s_ready[grant] = (state==PAYLOAD) & (!tx_valid | tx_ready). Non-granted s_ready=0 always. s_ready is combinational.
    - On s_valid & s_ready:
      - tx_data <= s_data; tx_valid <= 1; checksum ^= s_data.
      - If s_last, go to CSUM.
    - Sustained throughput: one byte per clock when tx_ready is held high.
  - CSUM
    - On entry, once the last payload byte transfers, load tx_data=checksum, tx_valid=1.
    - The checksum covers payload bytes only. SYNC and ID are excluded.
    - On transfer, pulse pkt_done and go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: count GAP_CYCLES clocks with tx_valid=0, then go to IDLE.
- Boundaries:
  - Single-byte packet (s_last on the first byte) is legal: 4 bytes on the wire.
  - Channel valid dropping mid-packet: stall in PAYLOAD indefinitely; no timeout.
  - The other channel's s_valid during a packet is ignored until IDLE.
  - tx_ready held low stalls any state with tx_data stable.
  - Checksum resets to 0 at every new packet.

Test Plan:
- Reset, then ch0 sends payload {8'h01,8'h02,8'h03} with last on 8'h03, tx_ready=1.
  - Required: tx stream A5,00,01,02,03,00 (checksum 01^02^03=00).
  - Required: pkt_done exactly once; busy returns to 0 after 4 gap clocks.
- Both channels valid at the same edge after reset.
  - Required: ch0 packet first (grant=0), then ch1 (ID byte 01).
  - Repeat with both valid: ch0 again after ch1 (alternation).
- ch1 single byte 8'h5A, tx_ready toggled 1/0 every cycle.
  - Required: stream A5,01,5A,5A. tx_data is never changed while tx_valid=1 & tx_ready=0.
- ch1 streaming 8 bytes with tx_ready=1.
  - Required: 8 payload bytes on 8 consecutive clocks.
  - Required: ch0 asserting valid mid-packet gets s0_ready=0 throughout.
- rst pulsed for one clock while in PAYLOAD.
  - Required next cycle: tx_valid=0, busy=0, grant=1, no checksum byte.
  - A following ch0 request produces a clean packet starting with A5.
- GAP_CYCLES=0 instance, ch0 and ch1 back-to-back.
  - Required: the second SYNC_BYTE appears one clock after the first packet's checksum transfer.
